// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcodes, FSM states and
// the helper that decides which opcodes touch the HI/LO pair.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MADD  = 4'd3,
    OP_MADDU = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10,
    OP_MFHI  = 4'd11,
    OP_MFLO  = 4'd12
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2
  } muldiv_state_t;

  // Unlisted encodings fall into the default arm and behave like OP_NONE.
  function automatic logic is_hilo_access(input muldiv_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
      OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mul_op(input muldiv_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_muldiv_divider.sv
// Radix-2 restoring divider on operand magnitudes, one iteration per cycle.
// The final iteration and sign fix-up are combinational so the result is ready on the last edge.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  logic             running_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dsr_q, raw_a_q;
  logic             neg_quo_q, neg_rem_q, zero_q;

  logic [WIDTH:0]   rem_shift, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr_q};
    fits      = ~diff[WIDTH];
    rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], fits};
    valid     = running_q && (cnt_q == CNT_W'(WIDTH - 1));
    // Divide by zero reports all-ones quotient and the raw dividend regardless of signedness.
    if (zero_q) begin
      quotient  = '1;
      remainder = raw_a_q;
    end else begin
      quotient  = neg_quo_q ? -quo_next : quo_next;
      remainder = neg_rem_q ? -rem_next : rem_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      raw_a_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else if (abort) begin
      running_q <= 1'b0;
    end else if (start) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      dsr_q     <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
      raw_a_q   <= dividend;
      neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_q <= is_signed && dividend[WIDTH-1];
      zero_q    <= (divisor == '0);
    end else if (running_q) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (valid) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO owner: multicycle multiply/accumulate, restoring divide,
// MTHI/MTLO writes, with accept/busy/stall handshake and abort.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  muldiv_op_t       op,
  input  logic             op_valid,
  input  logic             commit,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             op_accept,
  output logic             busy,
  output logic             hilo_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int W2 = 2 * WIDTH;

  muldiv_state_t    state_q, state_d;
  logic [2:0]       mul_cnt_q;
  logic [W2-1:0]    mul_res_q, mul_res, prod_s, prod_u, prod;
  logic             access, is_mul, is_div, signed_mul;
  logic             mul_write, div_write, div_start, div_valid;
  logic [WIDTH-1:0] div_quo, div_rem;

  // The low 2*WIDTH bits of a product of sign-extended operands are the signed product.
  always_comb begin
    prod_s     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    signed_mul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    prod       = signed_mul ? prod_s : prod_u;
    case (op)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
  end

  always_comb begin
    access     = is_hilo_access(op);
    is_mul     = is_mul_op(op);
    is_div     = (op == OP_DIV) || (op == OP_DIVU);
    busy       = (state_q != IDLE);
    op_accept  = op_valid && commit && !busy && access && !abort;
    hilo_stall = op_valid && busy && access;
    div_start  = op_accept && is_div;
    mul_write  = (state_q == MUL_WAIT) && (mul_cnt_q == 3'd1) && !abort;
    div_write  = (state_q == DIV_RUN) && div_valid && !abort;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (op_accept && is_mul && (MUL_LAT > 1)) state_d = MUL_WAIT;
        else if (div_start)                       state_d = DIV_RUN;
      end
      MUL_WAIT: if (abort || mul_cnt_q == 3'd1) state_d = IDLE;
      DIV_RUN:  if (abort || div_valid)         state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  muldiv_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .is_signed (op == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .abort     (abort),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // HILO cannot change while busy, so accumulate results are formed at accept time.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      mul_cnt_q <= '0;
      mul_res_q <= '0;
    end else begin
      state_q <= state_d;
      done    <= mul_write || div_write;
      if (state_q == MUL_WAIT) mul_cnt_q <= mul_cnt_q - 3'd1;
      if (op_accept) begin
        case (op)
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= b;
          default: begin
            if (is_mul) begin
              if (MUL_LAT == 1) begin
                {hi, lo} <= mul_res;
              end else begin
                mul_res_q <= mul_res;
                mul_cnt_q <= 3'(MUL_LAT - 1);
              end
            end
          end
        endcase
      end
      if (mul_write) {hi, lo} <= mul_res_q;
      if (div_write) begin
        hi <= div_rem;
        lo <= div_quo;
      end
    end
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multicycle multiply/divide unit that owns the HI/LO register pair for the Execute stage.
- Generalises the fixed 32-bit HILO datapath:
  - WIDTH-bit operands.
  - Configurable multiply latency.
  - Explicit accept/busy handshake.
  - Abort of in-flight operations.
  - Internal radix-2 restoring divider.
- The ALU drives operations into it, reads HI/LO from it, and stalls on its hilo_stall output.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; minimum 8.
- MUL_LAT, 1, multiply/accumulate latency in cycles, 1..4; 1 means HILO is written on the accept edge.
- CNT_W, $clog2(WIDTH+1), width of the divide iteration counter (derived; do not override).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- op  in  4  operation code (package enum muldiv_op_t)
- op_valid  in  1  op is presented this cycle
- commit  in  1  pipeline may commit (deasserted on EX stall/flush); accept requires commit
- abort  in  1  cancel any in-flight operation; HILO left unchanged
- a  in  WIDTH  operand A (dividend / multiplicand / MTHI source)
- b  in  WIDTH  operand B (divisor / multiplier / MTLO source)
- op_accept  out  1  op taken this cycle
- busy  out  1  multicycle operation in flight
- hilo_stall  out  1  requester must stall (HILO access while busy)
- hi  out  WIDTH  current HI
- lo  out  WIDTH  current LO
- done  out  1  one-cycle pulse on the edge HILO receives a multicycle result

Behaviour:
- Reset (synchronous, priority over all):
  - hi = lo = 0, busy = 0, done = 0.
  - State IDLE, counter 0, multiply pipe cleared.
- Opcodes: NONE, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO. Any other code is treated as NONE.
- Access set: every code except NONE.
- Combinational outputs:
  - op_accept = op_valid & commit & ~busy & (op in access set).
  - hilo_stall = op_valid & busy & (op in access set).
- MFHI/MFLO: accepted, no state change; hi/lo are always valid when busy = 0.
- MTHI writes hi <= a; MTLO writes lo <= b. Both write on the accept edge.
- Multiply:
  - Product is 2*WIDTH bits: signed for MULT/MADD/MSUB, unsigned for the U variants.
  - MADD: HILO + product. MSUB: HILO - product. Arithmetic is modulo 2^(2*WIDTH).
  - Accept edge is E. HILO is written at edge E+MUL_LAT-1.
  - busy is high for the MUL_LAT-1 cycles after E. done pulses on the write edge only when MUL_LAT > 1.
- Divide:
  - The divider sub-module performs WIDTH restoring iterations, one per cycle, on magnitudes.
  - Signed results: quotient negated if the signs of a and b differ; remainder takes the sign of a.
  - Written as hi = remainder, lo = quotient at edge E+WIDTH.
  - busy is high from the cycle after E through edge E+WIDTH. done pulses at E+WIDTH.
- Divide by zero: still WIDTH cycles; lo = all ones, hi = a, for both signed and unsigned.
- Signed MIN / -1: lo = MIN, hi = 0.
- FSM:
  - IDLE -> MUL_WAIT on accepted multiply op with MUL_LAT > 1.
  - IDLE -> DIV_RUN on accepted DIV/DIVU.
  - MUL_WAIT -> IDLE when the latency counter expires. DIV_RUN -> IDLE when the counter reaches WIDTH.
  - Operands are latched at accept, so later changes to a/b are ignored.
- abort:
  - In MUL_WAIT/DIV_RUN: return to IDLE next edge; HILO unchanged, no done.
  - If abort coincides with the completion edge, abort wins.
  - In IDLE, abort blocks acceptance that cycle.
- Reset mid-operation: immediate return to IDLE, HILO cleared, no done.
- Non-access ops (NONE) pass freely while busy; op_accept = 0.

Decomposition:
- Shared package muldiv_pkg holds:
  - muldiv_op_t enum, 4-bit encodings in the listed order starting at 0.
  - The state enum (IDLE, MUL_WAIT, DIV_RUN).
  - Helper function is_hilo_access(op).
- One sub-module, muldiv_divider:
  - Parametrised by WIDTH.
  - start, is_signed, dividend, divisor, abort in; quotient, remainder, valid out.
  - Owns the iteration counter and the sign fix-up.

Test Plan:
- Reset, then MTHI a=0x12345678 and MTLO b=0x9ABCDEF0 -> hi/lo equal those values one edge later; busy stays 0.
- MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MADD with HILO=0x00000000_00000010, a=4, b=5, MUL_LAT=3 -> busy for 2 cycles, done pulse, HILO=0x00000000_00000024.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 32 cycles, MFLO during busy gives hilo_stall=1, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- DIV started, abort at cycle 10 -> busy falls next edge, HILO keeps its pre-divide value, no done. A following DIVU 9/4 gives lo=2, hi=1.
- Reset asserted at cycle 15 of a divide -> hi=lo=0, busy=0, and the next op is accepted the cycle after reset drops.
